// File: rtl/dac_ramp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : dac_ramp_gen
//  Purpose  : Sawtooth / triangle ramp generator for a DAC data path. A
//             fixed-point accumulator (integer part = DAC code) is stepped
//             once per clock between a signed lower and upper bound. The
//             configuration is captured into shadow registers by load_in and
//             only becomes active at a safe point: immediately while idle,
//             otherwise at a period boundary (wrap) or, in triangle mode, at
//             the top turn-around.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in       in   1   DAC data clock, rising edge
//    rst_in       in   1   asynchronous reset, active low
//    on_in        in   1   1 = sweep runs, 0 = return to idle
//    mode_in      in   1   0 = sawtooth, 1 = triangle (captured by load_in)
//    minval_in    in   W   signed lower bound (captured by load_in)
//    maxval_in    in   W   signed upper bound (captured by load_in)
//    stepsize_in  in   W+F unsigned accumulator increment per clock
//    load_in      in   1   one-cycle pulse, captures the four fields above
//    signal_out   out  W   signed DAC code, registered accumulator top bits
//    dir_out      out  1   1 while the ramp is falling
//    wrap_out     out  1   one-cycle pulse at each period boundary
//    err_out      out  1   level, active config has min >= max
// ============================================================================
module dac_ramp_gen #(
  parameter int SIGNAL_OUT_SIZE = 16,
  parameter int ACC_FRAC        = 16
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                on_in,
  input  logic                                mode_in,
  input  logic [SIGNAL_OUT_SIZE-1:0]          minval_in,
  input  logic [SIGNAL_OUT_SIZE-1:0]          maxval_in,
  input  logic [SIGNAL_OUT_SIZE+ACC_FRAC-1:0] stepsize_in,
  input  logic                                load_in,
  output logic [SIGNAL_OUT_SIZE-1:0]          signal_out,
  output logic                                dir_out,
  output logic                                wrap_out,
  output logic                                err_out
);

  localparam int c_acc_w = SIGNAL_OUT_SIZE + ACC_FRAC;
  // Two guard bits: acc (signed) +/- step (unsigned, up to 2^acc_w-1)
  // always fits, so bound comparisons never see a wrapped value.
  localparam int c_ext_w = c_acc_w + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [c_acc_w-1:0]           r_acc;
  logic [c_acc_w-1:0]           w_acc_nxt;
  logic [SIGNAL_OUT_SIZE-1:0]   r_signal;
  logic                         r_dir;
  logic                         r_wrap;
  logic                         w_wrap;
  logic                         w_turn;

  // Shadow configuration, written by every load_in pulse.
  logic                         r_sh_mode;
  logic [SIGNAL_OUT_SIZE-1:0]   r_sh_min;
  logic [SIGNAL_OUT_SIZE-1:0]   r_sh_max;
  logic [c_acc_w-1:0]           r_sh_step;

  // Active configuration, the one the ramp actually uses.
  logic                         r_mode;
  logic [SIGNAL_OUT_SIZE-1:0]   r_min;
  logic [SIGNAL_OUT_SIZE-1:0]   r_max;
  logic [c_acc_w-1:0]           r_step;

  // Source for an active-config update: a load coinciding with the commit
  // point wins over the older shadow contents.
  logic                         w_cfg_mode;
  logic [SIGNAL_OUT_SIZE-1:0]   w_cfg_min;
  logic [SIGNAL_OUT_SIZE-1:0]   w_cfg_max;
  logic [c_acc_w-1:0]           w_cfg_step;
  logic                         w_cfg_commit;

  logic                         w_err;
  logic [c_acc_w-1:0]           w_min_acc;
  logic [c_acc_w-1:0]           w_max_acc;
  logic signed [c_ext_w-1:0]    w_acc_ext;
  logic signed [c_ext_w-1:0]    w_step_ext;
  logic signed [c_ext_w-1:0]    w_min_ext;
  logic signed [c_ext_w-1:0]    w_max_ext;
  logic signed [c_ext_w-1:0]    w_sum;
  logic signed [c_ext_w-1:0]    w_diff;

  assign w_err      = ($signed(r_min) >= $signed(r_max));

  assign w_min_acc  = {r_min, {ACC_FRAC{1'b0}}};
  assign w_max_acc  = {r_max, {ACC_FRAC{1'b0}}};
  assign w_acc_ext  = {{2{r_acc[c_acc_w-1]}}, r_acc};
  assign w_step_ext = {2'b00, r_step};
  assign w_min_ext  = {{2{w_min_acc[c_acc_w-1]}}, w_min_acc};
  assign w_max_ext  = {{2{w_max_acc[c_acc_w-1]}}, w_max_acc};
  assign w_sum      = w_acc_ext + w_step_ext;
  assign w_diff     = w_acc_ext - w_step_ext;

  // --------------------------------------------------------------------------
  // Next-state / next-accumulator logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_wrap      = 1'b0;
    w_turn      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_acc_nxt = w_min_acc;
        if (on_in && !w_err) begin
          w_state_nxt = ST_UP;
        end
      end

      ST_UP: begin
        if (w_sum > w_max_ext) begin
          if (r_mode) begin
            // Triangle: clamp to the top and turn; the top code dwells one
            // extra clock because the clamp itself is a sample.
            w_acc_nxt   = w_max_acc;
            w_state_nxt = ST_DOWN;
            w_turn      = 1'b1;
          end else begin
            w_acc_nxt = w_min_acc;
            w_wrap    = 1'b1;
          end
        end else begin
          w_acc_nxt = w_sum[c_acc_w-1:0];
        end
      end

      ST_DOWN: begin
        if (w_diff < w_min_ext) begin
          w_acc_nxt   = w_min_acc;
          w_state_nxt = ST_UP;
          w_wrap      = 1'b1;
        end else begin
          w_acc_nxt = w_diff[c_acc_w-1:0];
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_acc_nxt   = w_min_acc;
      end
    endcase

    // Switching off (or an invalid config) overrides the ramp, but a wrap
    // computed on this same clock is still reported.
    if ((r_state != ST_IDLE) && (!on_in || w_err)) begin
      w_state_nxt = ST_IDLE;
      w_acc_nxt   = w_min_acc;
    end
  end

  assign w_cfg_commit = (r_state == ST_IDLE) || w_wrap || w_turn;
  assign w_cfg_mode   = load_in ? mode_in     : r_sh_mode;
  assign w_cfg_min    = load_in ? minval_in   : r_sh_min;
  assign w_cfg_max    = load_in ? maxval_in   : r_sh_max;
  assign w_cfg_step   = load_in ? stepsize_in : r_sh_step;

  // --------------------------------------------------------------------------
  // Configuration registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_sh_mode <= 1'b0;
      r_sh_min  <= '0;
      r_sh_max  <= '0;
      r_sh_step <= '0;
      r_mode    <= 1'b0;
      r_min     <= '0;
      r_max     <= '0;
      r_step    <= '0;
    end else begin
      if (load_in) begin
        r_sh_mode <= mode_in;
        r_sh_min  <= minval_in;
        r_sh_max  <= maxval_in;
        r_sh_step <= stepsize_in;
      end
      if (w_cfg_commit) begin
        r_mode <= w_cfg_mode;
        r_min  <= w_cfg_min;
        r_max  <= w_cfg_max;
        r_step <= w_cfg_step;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Ramp state, accumulator and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_signal <= '0;
      r_dir    <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      // Output shows the accumulator one clock after it is loaded; dir is
      // taken from the same earlier clock so both stay aligned.
      r_signal <= r_acc[c_acc_w-1:ACC_FRAC];
      r_dir    <= (r_state == ST_DOWN);
      r_wrap   <= w_wrap;
    end
  end

  assign signal_out = r_signal;
  assign dir_out    = r_dir;
  assign wrap_out   = r_wrap;
  assign err_out    = w_err;

endmodule
`default_nettype wire

// File: tb/tb_dac_ramp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_ramp_gen
//  Purpose  : Directed self-checking bench for dac_ramp_gen with
//             hand-computed expected sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dac_ramp_gen;

  logic        clk_in;
  logic        rst_in;
  logic        on_in;
  logic        mode_in;
  logic [15:0] minval_in;
  logic [15:0] maxval_in;
  logic [31:0] stepsize_in;
  logic        load_in;
  logic [15:0] signal_out;
  logic        dir_out;
  logic        wrap_out;
  logic        err_out;

  int vectors;
  int miscompares;

  dac_ramp_gen #(
    .SIGNAL_OUT_SIZE(16),
    .ACC_FRAC       (16)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .on_in      (on_in),
    .mode_in    (mode_in),
    .minval_in  (minval_in),
    .maxval_in  (maxval_in),
    .stepsize_in(stepsize_in),
    .load_in    (load_in),
    .signal_out (signal_out),
    .dir_out    (dir_out),
    .wrap_out   (wrap_out),
    .err_out    (err_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Expected outputs, one entry per clock after the sweep starts.
  logic [15:0] saw_sig  [10] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4,
                                 16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
  logic        saw_wrap [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] tri_sig  [12] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd4,
                                 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd1};
  logic        tri_dir  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        tri_wrap [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] mid_sig  [6]  = '{16'd3, 16'd4, 16'd0, 16'd1, 16'd2, 16'd0};
  logic        mid_wrap [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] coin_sig [4]  = '{16'd0, 16'd1, 16'd2, 16'd3};
  logic        coin_wrap[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive a configuration and pulse load_in for one clock.
  task automatic cfg(input logic m, input logic [15:0] mn, input logic [15:0] mx,
                     input logic [31:0] st);
    mode_in     = m;
    minval_in   = mn;
    maxval_in   = mx;
    stepsize_in = st;
    load_in     = 1'b1;
    tick();
    load_in     = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_in      = 1'b0;
    on_in       = 1'b0;
    mode_in     = 1'b0;
    minval_in   = '0;
    maxval_in   = '0;
    stepsize_in = '0;
    load_in     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_sig",  {16'd0, signal_out}, 32'd0);
    chk("rst_dir",  {31'd0, dir_out},    32'd0);
    chk("rst_wrap", {31'd0, wrap_out},   32'd0);
    chk("rst_err",  {31'd0, err_out},    32'd1);
    rst_in = 1'b1;

    // on_in without any load keeps the default (invalid) config idle
    on_in = 1'b1;
    repeat (3) tick();
    chk("noload_sig", {16'd0, signal_out}, 32'd0);
    chk("noload_err", {31'd0, err_out},    32'd1);
    on_in = 1'b0;
    tick();

    // Sawtooth 0..4
    cfg(1'b0, 16'h0000, 16'h0004, 32'h0001_0000);
    chk("saw_err", {31'd0, err_out}, 32'd0);
    on_in = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("saw_sig",  {16'd0, signal_out}, {16'd0, saw_sig[i]});
      chk("saw_wrap", {31'd0, wrap_out},   {31'd0, saw_wrap[i]});
    end
    tick();
    tick();
    chk("pre_off_sig", {16'd0, signal_out}, 32'd1);
    on_in = 1'b0;
    tick();
    chk("off_wrap0", {31'd0, wrap_out}, 32'd0);
    tick();
    chk("off_sig",   {16'd0, signal_out}, 32'd0);
    chk("off_wrap1", {31'd0, wrap_out},   32'd0);
    chk("off_dir",   {31'd0, dir_out},    32'd0);

    // Triangle 0..4
    cfg(1'b1, 16'h0000, 16'h0004, 32'h0001_0000);
    on_in = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("tri_sig",  {16'd0, signal_out}, {16'd0, tri_sig[i]});
      chk("tri_dir",  {31'd0, dir_out},    {31'd0, tri_dir[i]});
      chk("tri_wrap", {31'd0, wrap_out},   {31'd0, tri_wrap[i]});
    end

    // Reset asserted mid-ramp takes effect without a clock
    rst_in = 1'b0;
    #2;
    chk("arst_sig",  {16'd0, signal_out}, 32'd0);
    chk("arst_wrap", {31'd0, wrap_out},   32'd0);
    chk("arst_dir",  {31'd0, dir_out},    32'd0);
    chk("arst_err",  {31'd0, err_out},    32'd1);
    on_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    chk("arst_rel_sig", {16'd0, signal_out}, 32'd0);

    // New max loaded mid-period: old max finishes the period
    cfg(1'b0, 16'h0000, 16'h0004, 32'h0001_0000);
    on_in = 1'b1;
    tick();
    tick();
    tick();
    maxval_in = 16'h0002;
    load_in   = 1'b1;
    tick();
    load_in   = 1'b0;
    chk("mid_sig0",  {16'd0, signal_out}, 32'd2);
    chk("mid_wrap0", {31'd0, wrap_out},   32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_sig",  {16'd0, signal_out}, {16'd0, mid_sig[i]});
      chk("mid_wrap", {31'd0, wrap_out},   {31'd0, mid_wrap[i]});
    end

    // Load coincident with a boundary becomes active on that boundary
    tick();
    maxval_in = 16'h0003;
    load_in   = 1'b1;
    tick();
    load_in   = 1'b0;
    chk("coin_sig0",  {16'd0, signal_out}, 32'd2);
    chk("coin_wrap0", {31'd0, wrap_out},   32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("coin_sig",  {16'd0, signal_out}, {16'd0, coin_sig[i]});
      chk("coin_wrap", {31'd0, wrap_out},   {31'd0, coin_wrap[i]});
    end
    on_in = 1'b0;
    tick();
    tick();

    // Zero step holds the accumulator
    cfg(1'b0, 16'h0002, 16'h0009, 32'h0000_0000);
    on_in = 1'b1;
    tick();
    tick();
    chk("step0_sig0", {16'd0, signal_out}, 32'd2);
    repeat (3) begin
      tick();
      chk("step0_sig",  {16'd0, signal_out}, 32'd2);
      chk("step0_wrap", {31'd0, wrap_out},   32'd0);
    end
    on_in = 1'b0;
    tick();

    // Full-scale bounds with maximum step: no overflow, immediate wrap
    cfg(1'b0, 16'h8000, 16'h7FFF, 32'hFFFF_FFFF);
    chk("ext_err", {31'd0, err_out}, 32'd0);
    on_in = 1'b1;
    tick();
    repeat (3) begin
      tick();
      chk("ext_sig",  {16'd0, signal_out}, 32'h0000_8000);
      chk("ext_wrap", {31'd0, wrap_out},   32'd1);
    end
    on_in = 1'b0;
    tick();

    // min == max and min > max flag an error and pin the output at min
    cfg(1'b0, 16'h0005, 16'h0005, 32'h0001_0000);
    chk("eq_err", {31'd0, err_out}, 32'd1);
    on_in = 1'b1;
    tick();
    tick();
    chk("eq_sig",  {16'd0, signal_out}, 32'd5);
    chk("eq_wrap", {31'd0, wrap_out},   32'd0);
    tick();
    chk("eq_sig2", {16'd0, signal_out}, 32'd5);
    on_in = 1'b0;
    cfg(1'b0, 16'h0010, 16'hFFF0, 32'h0001_0000);
    chk("gt_err", {31'd0, err_out}, 32'd1);
    tick();

    // Slow sawtooth: one code per 128 clocks
    cfg(1'b0, 16'h0000, 16'h7FFF, 32'h0000_0200);
    on_in = 1'b1;
    tick();
    repeat (128) tick();
    chk("slow_sig0", {16'd0, signal_out}, 32'd0);
    tick();
    chk("slow_sig1", {16'd0, signal_out}, 32'd1);
    repeat (128) tick();
    chk("slow_sig2", {16'd0, signal_out}, 32'd2);
    on_in = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
